seq_signed_div: RTL

- Iterative signed divider, the inverse of the common-logic signed multiplier. It recovers operands from products, e.g. prod / mult_a -> mult_b.
- Accepts a signed dividend and a signed divisor over a valid/ready handshake.
- Computes one quotient bit per cycle by restoring division on magnitudes, then returns the quotient and remainder over a second valid/ready handshake.
- Instantiated in common logic, so it is present for every board_version.

---
 rtl/seq_signed_div_pkg.sv | 26 ++
 rtl/seq_signed_div.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_signed_div_pkg.sv
// Shared types and helpers for the iterative signed divider.
package seq_signed_div_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default operand widths.
  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;

  // Width of the sign-extended operand handed to abs_mag().
  localparam int MAG_W = 32;

  // Unsigned magnitude of a sign-extended two's-complement value. The
  // most-negative value of a narrower operand maps to 2**(w-1), which
  // still fits once the result is truncated back to the operand width.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] v);
    return v[MAG_W-1] ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_signed_div.sv
// Iterative signed divider: restoring division on operand magnitudes,
// one quotient bit per cycle, signs applied in a final fix-up cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid, once raised, holds with stable payload until that
// edge; ready may change freely and carries no commitment on its own.
module seq_signed_div
  import seq_signed_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  input  logic [DIVISOR_W-1:0]  in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quot,
  output logic [DIVISOR_W-1:0]  out_rem,
  output logic                  out_div0,
  output logic                  out_ovf,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int PART_W = DIVISOR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  state_t                state_q, state_d;
  // dvd_q starts as |dividend| and is shifted out MSB-first while the
  // quotient bits are shifted in at the bottom, so it ends as |quotient|.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  // Partial remainder is always < |divisor| <= 2**(DIVISOR_W-1), so
  // DIVISOR_W bits hold it between steps.
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  quot_neg_q, quot_neg_d;
  logic [DIVIDEND_W-1:0] out_quot_q, out_quot_d;
  logic [DIVISOR_W-1:0]  out_rem_q, out_rem_d;
  logic                  out_div0_q, out_div0_d;
  logic                  out_ovf_q, out_ovf_d;

  logic [DIVIDEND_W-1:0] in_dvd_mag;
  logic [DIVISOR_W-1:0]  in_dvs_mag;
  logic [PART_W-1:0]     part;
  logic                  part_ge;
  logic [DIVISOR_W-1:0]  part_sub;
  logic [DIVIDEND_W-1:0] quot_signed;
  logic [DIVISOR_W-1:0]  rem_signed;
  logic                  quot_ovf;

  // Operand magnitudes, one restoring step, and sign fix-up values.
  always_comb begin
    in_dvd_mag = DIVIDEND_W'(abs_mag({{(MAG_W-DIVIDEND_W){in_dividend[DIVIDEND_W-1]}},
                                      in_dividend}));
    in_dvs_mag = DIVISOR_W'(abs_mag({{(MAG_W-DIVISOR_W){in_divisor[DIVISOR_W-1]}},
                                     in_divisor}));
    part        = {rem_q, dvd_q[DIVIDEND_W-1]};
    part_ge     = (part >= {1'b0, dvs_q});
    part_sub    = DIVISOR_W'(part - {1'b0, dvs_q});
    quot_signed = quot_neg_q ? (~dvd_q + DIVIDEND_W'(1)) : dvd_q;
    rem_signed  = dvd_neg_q ? (~rem_q + DIVISOR_W'(1)) : rem_q;
    // A positive quotient whose magnitude has the MSB set cannot be
    // represented: only most-negative / -1 gets here, and it wraps.
    quot_ovf    = !quot_neg_q && dvd_q[DIVIDEND_W-1];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dvd_neg_d  = dvd_neg_q;
    quot_neg_d = quot_neg_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_div0_d = out_div0_q;
    out_ovf_d  = out_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_neg_d  = in_dividend[DIVIDEND_W-1];
          quot_neg_d = in_dividend[DIVIDEND_W-1] ^ in_divisor[DIVISOR_W-1];
          dvd_d      = in_dvd_mag;
          dvs_d      = in_dvs_mag;
          rem_d      = '0;
          cnt_d      = CNT_LOAD;
          out_div0_d = 1'b0;
          out_ovf_d  = 1'b0;
          if (in_divisor == '0) begin
            out_quot_d = '1;
            out_rem_d  = '0;
            out_div0_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], part_ge};
        rem_d = part_ge ? part_sub : part[DIVISOR_W-1:0];
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        out_quot_d = quot_signed;
        out_rem_d  = rem_signed;
        out_ovf_d  = quot_ovf;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dvd_neg_q  <= 1'b0;
      quot_neg_q <= 1'b0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_div0_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dvd_neg_q  <= dvd_neg_d;
      quot_neg_q <= quot_neg_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_div0_q <= out_div0_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_div0  = out_div0_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

endmodule
